demux_1x2_stream: RTL
=====================

# demux_1x2_stream

Buffered 1-to-2 stream demultiplexer: accepts one BITS-wide valid/ready input stream carrying a per-beat channel select and steers each beat into one of two independent output FIFOs, each with its own valid/ready handshake. It is the receive-side counterpart of the 2:1 mux. It splits a time-multiplexed stream back into its two source channels, so that each consumer can stall independently without losing data.

## Interface
- BITS, 4, data width of every beat.
- DEPTH, 4, entries per output FIFO; power of two, >= 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  BITS  input beat payload.
- in_sel  input  1  destination of the beat: 0 -> channel 0, 1 -> channel 1.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out0_data  output  BITS  channel 0 head entry.
- out0_valid  output  1  channel 0 FIFO non-empty.
- out0_ready  input  1  channel 0 consumer takes the head.
- out0_count  output  $clog2(DEPTH)+1  channel 0 occupancy, 0..DEPTH.
- out1_data, out1_valid, out1_ready, out1_count: identical to channel 0, for channel 1.

## Operation
- Each channel has its own FIFO, built from a DEPTH-entry register array, a write pointer, a read pointer (both $clog2(DEPTH) bits, natural wrap) and an occupancy counter.
- in_ready = !full[in_sel], where full[n] = (outn_count == DEPTH). in_ready is combinational from in_sel and the count registers.
- Push: when in_valid && in_ready, in_data is written to FIFO[in_sel] at wptr, wptr increments, and the count increments. The other channel is untouched.
- Pop: when outn_valid && outn_ready, rptr increments and the count decrements.
  - A pop while empty is ignored, and outn_ready has no effect.
- Simultaneous push and pop on the same channel: both occur and the count is unchanged.
  - When full, in_ready is 0 that cycle regardless of the pop (no pass-through).
  - When empty, the pushed beat is not visible until the next cycle (no bypass).
- Simultaneous pops on both channels are independent.
- outn_valid = (outn_count != 0).
- outn_data = mem[rptr] when valid, otherwise forced to 0.
- The input side must hold in_data and in_sel stable while in_valid && !in_ready. The block does not check this.
- Ordering: beats leave each channel in the order they were accepted for that channel.
- Beats are never dropped or duplicated.

## Timing
- Reset (rst high at a clk edge) clears all pointers and counts. The following outputs then read 0: outn_valid, outn_count, outn_data. in_ready reads 1.
  - Memory contents are not reset.
- Reset mid-operation discards all buffered beats in both channels. A handshake in the same cycle as rst is ignored.
- Latency is 1 cycle: a beat accepted at edge k appears as outn_valid and outn_data after edge k.
- Throughput is 1 beat per cycle on the input and 1 beat per cycle per output.
- Count, valid and in_ready update only at clk edges. in_ready also follows in_sel combinationally.
- Pointer wrap: the entry after index DEPTH-1 is 0. Occupancy is tracked by the counter, not by pointer comparison.

## Test plan
All scenarios use BITS=4 and DEPTH=4.
- Reset: drive rst=1 for 2 cycles with in_valid=1.
  - Response: out0_valid=out1_valid=0, both counts 0, both data 0, in_ready=1.
  - After release, nothing has been written.
- Steering: push 0xA with sel 0, 0x5 with sel 1, 0x3 with sel 0, with both readies held low.
  - Response: out0_count=2, out0_data=0xA; out1_count=1, out1_data=0x5.
  - Then pulse out0_ready for one cycle: out0_data=0x3, out0_count=1.
- Full/backpressure: push 0x1..0x4 to channel 0, then offer 0x6 with sel 0.
  - Response: in_ready=0 and out0_count stays 4.
  - Switching in_sel to 1 gives in_ready=1 in the same cycle, and 0x6 lands in channel 1.
- Full with simultaneous pop: channel 0 is full, out0_ready=1 and in_valid=1 with sel 0.
  - Response: in_ready=0, the pop occurs and the count becomes 3.
  - On the next cycle the push is accepted and the count returns to 4.
- Wrap and throughput: stream 12 beats 0x0..0xB to channel 1 with out1_ready=1 continuously.
  - Response: in_ready stays 1 and out1_data follows in_data with one cycle of lag.
  - The order is preserved across 3 pointer wraps and the count never exceeds 1.
- Mid-operation reset: with 3 beats buffered in channel 0 and 2 in channel 1, assert rst for 1 cycle.
  - Response: both counts are 0 and both valids are 0.
  - The next push of 0x9 with sel 1 appears as out1_data=0x9 one cycle later.

Source files
------------

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: steers each accepted input beat into one of two
// independent output FIFOs selected by in_sel. Each FIFO is a register
// array with wrap-around pointers and an explicit occupancy counter.
module demux_1x2_stream #(
    parameter int BITS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS-1:0]          in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BITS-1:0]          out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic [BITS-1:0]          out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BITS-1:0] r_mem   [2][DEPTH];
    logic [AW-1:0]   r_wptr  [2];
    logic [AW-1:0]   r_rptr  [2];
    logic [CW-1:0]   r_count [2];

    logic [1:0]      w_full;
    logic [1:0]      w_valid;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [BITS-1:0] w_head [2];

    // Per-channel status, handshake qualification and head selection
    always_comb begin
        w_full  = '0;
        w_valid = '0;
        w_push  = '0;
        w_pop   = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            w_full[ch]  = (r_count[ch] == CW'(DEPTH));
            w_valid[ch] = (r_count[ch] != '0);
            w_head[ch]  = w_valid[ch] ? r_mem[ch][r_rptr[ch]] : '0;
        end
        in_ready  = !w_full[in_sel];
        w_push[0] = in_valid && in_ready && !in_sel;
        w_push[1] = in_valid && in_ready &&  in_sel;
        w_pop[0]  = w_valid[0] && out0_ready;
        w_pop[1]  = w_valid[1] && out1_ready;
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_head[0];
    assign out1_data  = w_head[1];
    assign out0_count = r_count[0];
    assign out1_count = r_count[1];

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (!rst && w_push[ch]) begin
                r_mem[ch][r_wptr[ch]] <= in_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping for both channels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                r_wptr[ch]  <= '0;
                r_rptr[ch]  <= '0;
                r_count[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                if (w_push[ch]) begin
                    r_wptr[ch] <= r_wptr[ch] + 1'b1;
                end
                if (w_pop[ch]) begin
                    r_rptr[ch] <= r_rptr[ch] + 1'b1;
                end
                if (w_push[ch] && !w_pop[ch]) begin
                    r_count[ch] <= r_count[ch] + 1'b1;
                end else if (w_pop[ch] && !w_push[ch]) begin
                    r_count[ch] <= r_count[ch] - 1'b1;
                end
            end
        end
    end

endmodule
